// File: rtl/sa_feed_sequencer.sv
// sa_feed_sequencer
//   Runs one operand job for a systolic array. The job clears the
//   accumulators, streams K_LEN operand vectors out of the operand buffer,
//   skews each vector across the array lanes, waits for the array to drain,
//   and then pulses DONE.
//
// Ports
//   CLK, RST          rising-edge clock; synchronous active-high reset
//   START, ABORT      job request (taken only when idle) / job cancel
//   K_LEN, BASE_ADDR  vector count and buffer address of vector 0,
//                     both captured together with START
//   MEM_RE, MEM_ADDR  operand buffer read port
//   MEM_RDATA         read data, one cycle after MEM_RE; A lanes in the low
//                     half, B lanes in the high half
//   AA, BB            skewed A / B feeds; an idle lane is driven to zero
//   SA_CLR, SA_EN     accumulator clear pulse / array compute enable
//   BUSY, DONE        job in progress / one-cycle result-valid pulse
module sa_feed_sequencer #(
  parameter int WIDTH    = 8,
  parameter int HPE      = 4,
  parameter int VPE      = 4,
  parameter int PIPE_LAT = 2,
  parameter int AW       = 14
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        ABORT,
  input  logic [15:0]                 K_LEN,
  input  logic [AW-1:0]               BASE_ADDR,
  output logic                        MEM_RE,
  output logic [AW-1:0]               MEM_ADDR,
  input  logic [WIDTH*(HPE+VPE)-1:0]  MEM_RDATA,
  output logic [WIDTH*HPE-1:0]        AA,
  output logic [WIDTH*VPE-1:0]        BB,
  output logic                        SA_CLR,
  output logic                        SA_EN,
  output logic                        BUSY,
  output logic                        DONE
);

  // The drain time covers the deepest skew chain plus the array's own latency.
  localparam int FLUSH_LEN = HPE + VPE + PIPE_LAT;
  localparam int FCW       = $clog2(FLUSH_LEN + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [15:0]     r_k_len;
  logic [AW-1:0]   r_base;
  logic [15:0]     r_feed_cnt;
  logic [FCW-1:0]  r_flush_cnt;
  logic            r_mem_re;
  logic [AW-1:0]   r_mem_addr;
  logic            r_sa_clr;
  logic            r_sa_en;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_pend;   // a read was issued last cycle, MEM_RDATA is real

  state_t          w_state_nx;
  logic [15:0]     w_feed_cnt_nx;
  logic [FCW-1:0]  w_flush_cnt_nx;
  logic [AW-1:0]   w_addr_nx;
  logic            w_capture;
  logic            w_abort;     // cancel that actually takes effect this cycle

  // Next-state, counter and address decode.
  always_comb begin
    w_state_nx     = r_state;
    w_feed_cnt_nx  = r_feed_cnt;
    w_flush_cnt_nx = r_flush_cnt;
    w_addr_nx      = r_mem_addr;
    w_capture      = 1'b0;
    w_abort        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // START outranks ABORT here; ABORT alone is a no-op when idle.
        if (START) begin
          w_state_nx = ST_CLEAR;
          w_capture  = 1'b1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (ABORT) begin
          w_abort    = 1'b1;
          w_state_nx = ST_IDLE;
        end else if (r_k_len != 16'd0) begin
          w_state_nx    = ST_FEED;
          w_feed_cnt_nx = 16'd0;
          w_addr_nx     = r_base;
        end else begin
          w_state_nx = ST_DONE;
        end
      end
      ST_FEED: begin
        // r_k_len is non-zero here, so the subtraction cannot wrap.
        if (ABORT) begin
          w_abort    = 1'b1;
          w_state_nx = ST_IDLE;
        end else if (r_feed_cnt == (r_k_len - 16'd1)) begin
          w_state_nx     = ST_FLUSH;
          w_flush_cnt_nx = {FCW{1'b0}};
        end else begin
          w_feed_cnt_nx = r_feed_cnt + 16'd1;
          w_addr_nx     = r_mem_addr + AW'(1);
        end
      end
      ST_FLUSH: begin
        if (ABORT) begin
          w_abort    = 1'b1;
          w_state_nx = ST_IDLE;
        end else if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nx = ST_DONE;
        end else begin
          w_flush_cnt_nx = r_flush_cnt + FCW'(1);
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, job registers and control outputs; outputs follow the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_k_len     <= 16'd0;
      r_base      <= {AW{1'b0}};
      r_feed_cnt  <= 16'd0;
      r_flush_cnt <= {FCW{1'b0}};
      r_mem_re    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_sa_clr    <= 1'b0;
      r_sa_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_feed_cnt  <= w_feed_cnt_nx;
      r_flush_cnt <= w_flush_cnt_nx;
      r_mem_addr  <= w_addr_nx;
      if (w_capture) begin
        r_k_len <= K_LEN;
        r_base  <= BASE_ADDR;
      end
      r_mem_re  <= (w_state_nx == ST_FEED);
      r_sa_clr  <= (w_state_nx == ST_CLEAR);
      r_sa_en   <= (w_state_nx == ST_FEED) || (w_state_nx == ST_FLUSH);
      r_busy    <= (w_state_nx != ST_IDLE);
      r_done    <= (w_state_nx == ST_DONE);
      r_rd_pend <= w_abort ? 1'b0 : r_mem_re;
    end
  end

  assign MEM_RE   = r_mem_re;
  assign MEM_ADDR = r_mem_addr;
  assign SA_CLR   = r_sa_clr;
  assign SA_EN    = r_sa_en;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

  // Lane i is a chain of i+1 stages, so lane i lags lane 0 by i cycles.
  // Stage 0 loads zero whenever no read was issued, so stale MEM_RDATA
  // never enters a chain.
  for (genvar gi = 0; gi < HPE; gi++) begin : g_a_lane
    logic [WIDTH-1:0] r_d [gi+1];
    logic             r_v [gi+1];

    // A-lane shift chain.
    always_ff @(posedge CLK) begin
      if (RST || w_abort) begin
        for (int k = 0; k <= gi; k++) begin
          r_d[k] <= {WIDTH{1'b0}};
          r_v[k] <= 1'b0;
        end
      end else begin
        r_d[0] <= r_rd_pend ? MEM_RDATA[WIDTH*gi +: WIDTH] : {WIDTH{1'b0}};
        r_v[0] <= r_rd_pend;
        for (int k = 1; k <= gi; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    assign AA[WIDTH*gi +: WIDTH] = r_v[gi] ? r_d[gi] : {WIDTH{1'b0}};
  end

  for (genvar gj = 0; gj < VPE; gj++) begin : g_b_lane
    logic [WIDTH-1:0] r_d [gj+1];
    logic             r_v [gj+1];

    // B-lane shift chain.
    always_ff @(posedge CLK) begin
      if (RST || w_abort) begin
        for (int k = 0; k <= gj; k++) begin
          r_d[k] <= {WIDTH{1'b0}};
          r_v[k] <= 1'b0;
        end
      end else begin
        r_d[0] <= r_rd_pend ? MEM_RDATA[WIDTH*HPE + WIDTH*gj +: WIDTH] : {WIDTH{1'b0}};
        r_v[0] <= r_rd_pend;
        for (int k = 1; k <= gj; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    assign BB[WIDTH*gj +: WIDTH] = r_v[gj] ? r_d[gj] : {WIDTH{1'b0}};
  end

endmodule

// File: tb/tb_sa_feed_sequencer.sv
// tb_sa_feed_sequencer
//   Scoreboard bench for sa_feed_sequencer (WIDTH=8, HPE=VPE=4, PIPE_LAT=2,
//   AW=14). For every cycle of a job the expected outputs are computed from
//   the job timeline and pushed when the inputs are driven, then popped and
//   compared at the falling edge. A small buffer model answers reads one
//   cycle later and returns random data in cycles without a read.
module tb_sa_feed_sequencer;

  localparam int FL = 10;  // HPE + VPE + PIPE_LAT

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic [15:0] K_LEN;
  logic [13:0] BASE_ADDR;
  logic        MEM_RE;
  logic [13:0] MEM_ADDR;
  logic [63:0] MEM_RDATA;
  logic [31:0] AA;
  logic [31:0] BB;
  logic        SA_CLR;
  logic        SA_EN;
  logic        BUSY;
  logic        DONE;

  typedef struct {
    int          t;
    logic        mem_re;
    logic        chk_addr;
    logic [13:0] addr;
    logic        sa_clr;
    logic        sa_en;
    logic        busy;
    logic        done;
    logic [31:0] aa;
    logic [31:0] bb;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cur_t  = 0;

  sa_feed_sequencer #(
    .WIDTH(8), .HPE(4), .VPE(4), .PIPE_LAT(2), .AW(14)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .K_LEN(K_LEN), .BASE_ADDR(BASE_ADDR),
    .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .AA(AA), .BB(BB), .SA_CLR(SA_CLR), .SA_EN(SA_EN),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] a_elem(input logic [13:0] ad, input int i);
    if (ad == 14'h0010) return 8'(i + 1);
    return ad[7:0] ^ 8'(33 * (i + 1));
  endfunction

  function automatic logic [7:0] b_elem(input logic [13:0] ad, input int j);
    if (ad == 14'h0010) return 8'(128 + j);
    return ad[7:0] ^ 8'(90 + 3 * j) ^ {2'b00, ad[13:8]};
  endfunction

  function automatic logic [63:0] word(input logic [13:0] ad);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 4; i++) begin
      w[i*8 +: 8]      = a_elem(ad, i);
      w[32 + i*8 +: 8] = b_elem(ad, i);
    end
    return w;
  endfunction

  // Operand buffer: fixed one-cycle read latency, junk when not read.
  always @(posedge CLK) begin
    if (MEM_RE === 1'b1) MEM_RDATA <= word(MEM_ADDR);
    else                 MEM_RDATA <= {$urandom(), $urandom()};
  end

  // Expected outputs in cycle t of a job whose START is sampled in cycle 0.
  function automatic exp_t model(input int t, input int k, input logic [13:0] base,
                                 input int abort_at, input int rst_at);
    exp_t x;
    int   done_t;
    int   cut;
    int   c;
    logic feed;
    logic flush;
    x = '{t: t, mem_re: 1'b0, chk_addr: 1'b0, addr: 14'd0, sa_clr: 1'b0,
          sa_en: 1'b0, busy: 1'b0, done: 1'b0, aa: 32'd0, bb: 32'd0};
    done_t = (k == 0) ? 2 : k + FL + 2;
    cut = 1 << 30;
    if (abort_at >= 1 && abort_at < done_t) cut = abort_at + 1;
    if (rst_at >= 0 && rst_at + 1 < cut) cut = rst_at + 1;
    if (t >= cut) begin
      x.chk_addr = (rst_at >= 0) && (t == rst_at + 1);
      return x;
    end
    feed       = (k > 0) && (t >= 2) && (t <= k + 1);
    flush      = (k > 0) && (t >= k + 2) && (t <= k + FL + 1);
    x.mem_re   = feed;
    x.chk_addr = feed;
    x.addr     = 14'(int'(base) + t - 2);
    x.sa_clr   = (t == 1);
    x.sa_en    = feed || flush;
    x.busy     = (t >= 1) && (t <= done_t);
    x.done     = (t == done_t);
    for (int i = 0; i < 4; i++) begin
      c = t - 2 - i;
      if (k > 0 && c >= 2 && c <= k + 1) begin
        x.aa[i*8 +: 8] = a_elem(14'(int'(base) + c - 2), i);
        x.bb[i*8 +: 8] = b_elem(14'(int'(base) + c - 2), i);
      end
    end
    return x;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @t=%0d: got %0h, expected %0h", tag, cur_t, got, exp);
  endtask

  // Drive one job for ncyc cycles; t=0 is the START cycle. Extra START
  // pulses, ABORT and RST are placed at the given cycles (-1 = never).
  task automatic run_job(input int k, input logic [13:0] base, input int abort_at,
                         input int rst_at, input int xstart_at, input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      @(posedge CLK);
      #1;
      START     = (t == 0) || (t == xstart_at) || (t == rst_at);
      ABORT     = (t == abort_at);
      RST       = (t == rst_at);
      K_LEN     = (t == 0) ? 16'(k) : 16'($urandom());
      BASE_ADDR = (t == 0) ? base : 14'($urandom());
      sb_q.push_back(model(t, k, base, abort_at, rst_at));
      @(negedge CLK);
      e = sb_q.pop_front();
      cur_t = e.t;
      check_val("mem_re", 64'(MEM_RE), 64'(e.mem_re));
      if (e.chk_addr) check_val("mem_addr", 64'(MEM_ADDR), 64'(e.addr));
      check_val("sa_clr", 64'(SA_CLR), 64'(e.sa_clr));
      check_val("sa_en",  64'(SA_EN),  64'(e.sa_en));
      check_val("busy",   64'(BUSY),   64'(e.busy));
      check_val("done",   64'(DONE),   64'(e.done));
      check_val("aa",     64'(AA),     64'(e.aa));
      check_val("bb",     64'(BB),     64'(e.bb));
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b1; ABORT = 1'b0; K_LEN = 16'd5; BASE_ADDR = 14'h0123;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    cur_t = -1;
    // Reset state, with START held high alongside RST.
    check_val("rst_mem_re", 64'(MEM_RE),   64'd0);
    check_val("rst_addr",   64'(MEM_ADDR), 64'd0);
    check_val("rst_sa_clr", 64'(SA_CLR),   64'd0);
    check_val("rst_sa_en",  64'(SA_EN),    64'd0);
    check_val("rst_busy",   64'(BUSY),     64'd0);
    check_val("rst_done",   64'(DONE),     64'd0);
    check_val("rst_aa",     64'(AA),       64'd0);
    check_val("rst_bb",     64'(BB),       64'd0);

    // Nominal job, skew word at 0x10.
    run_job(3, 14'h0010, -1, -1, -1, 18);
    // Zero length with ABORT in the START cycle (START wins).
    run_job(0, 14'h0200, 0, -1, -1, 4);
    // Abort in FEED; the next job starts in the cycle right after.
    run_job(8, 14'h0040, 5, -1, -1, 6);
    run_job(2, 14'h0100, -1, -1, -1, 16);
    // Address wrap with an ignored START while busy.
    run_job(4, 14'h3FFE, -1, -1, 3, 18);
    // Reset in the middle of FEED, START with RST ignored.
    run_job(6, 14'h0200, -1, 3, -1, 8);
    // Single vector (isolated skew) with ABORT during DONE ignored.
    run_job(1, 14'h0010, 13, -1, -1, 15);
    // Abort in CLEAR and in FLUSH.
    run_job(5, 14'h0300, 1, -1, -1, 4);
    run_job(2, 14'h0310, 9, -1, -1, 12);
    // Longer job, feed counter beyond 8 bits and a wrap.
    run_job(300, 14'h3F80, -1, -1, -1, 314);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_feed_sequencer.md
SA_FEED_SEQUENCER -- requirements
Module: sa_feed_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, is the operand element width in bits.
REQ-002 Parameter HPE, default 4, is the number of horizontal PE lanes, i.e. the element count of the A operand.
REQ-003 Parameter VPE, default 4, is the number of vertical PE lanes, i.e. the element count of the B operand.
REQ-004 Parameter PIPE_LAT, default 2, is the extra array output latency in cycles added to the flush.
REQ-005 Parameter AW, default 14, is the operand buffer address width.
REQ-006 Port CLK, input, 1 bit: the single clock, rising edge.
REQ-007 Port RST, input, 1 bit: synchronous, active-high reset.
REQ-008 Port START, input, 1 bit: job request, sampled only in IDLE.
REQ-009 Port ABORT, input, 1 bit: cancels the current job.
REQ-010 Port K_LEN, input, 16 bits: number of operand vectors in the job, captured with START.
REQ-011 Port BASE_ADDR, input, AW bits: buffer address of vector 0, captured with START.
REQ-012 Port MEM_RE, output, 1 bit: operand buffer read enable.
REQ-013 Port MEM_ADDR, output, AW bits: operand buffer read address.
REQ-014 Port MEM_RDATA, input, WIDTH*(HPE+VPE) bits: read data with fixed 1-cycle latency. Bits [WIDTH*HPE-1:0] hold the A elements, lane i at [WIDTH*(i+1)-1:WIDTH*i]. The upper bits hold the B elements in the same lane order.
REQ-015 Port AA, output, WIDTH*HPE bits: skewed A feed to the systolic array.
REQ-016 Port BB, output, WIDTH*VPE bits: skewed B feed to the systolic array.
REQ-017 Port SA_CLR, output, 1 bit: accumulator clear pulse.
REQ-018 Port SA_EN, output, 1 bit: array compute enable.
REQ-019 Port BUSY, output, 1 bit: high while a job is in progress.
REQ-020 Port DONE, output, 1 bit: 1-cycle pulse when the result is valid.

Function
REQ-021 The FSM SHALL have the states IDLE, CLEAR, FEED, FLUSH and DONE, and all state and outputs SHALL be registered.
REQ-022 IDLE: START=1 SHALL capture K_LEN and BASE_ADDR and go to CLEAR; START=0 SHALL stay in IDLE.
REQ-023 CLEAR SHALL last exactly 1 cycle with SA_CLR=1, then go to FEED if K_LEN!=0, else go to DONE.
REQ-024 FEED SHALL last exactly K_LEN cycles with MEM_RE=1 and MEM_ADDR=BASE_ADDR+n in feed cycle n (n=0..K_LEN-1). MEM_ADDR SHALL wrap modulo 2^AW.
REQ-025 FLUSH SHALL last exactly HPE+VPE+PIPE_LAT cycles with MEM_RE=0, then go to DONE.
REQ-026 DONE SHALL last 1 cycle with DONE=1, then return to IDLE.
REQ-027 SA_EN SHALL be 1 in FEED and FLUSH only.
REQ-028 BUSY SHALL be 1 in CLEAR, FEED, FLUSH and DONE.
REQ-029 Skew: for vector n read in cycle c, AA lane i SHALL carry A element i in cycle c+2+i, and BB lane j SHALL carry B element j in cycle c+2+j.
REQ-030 Every AA/BB lane not carrying valid data in a given cycle SHALL be driven to zero.
REQ-031 Skew registers SHALL be per-lane shift chains of depth i+1 with a valid bit, and SHALL not use MEM_RDATA in cycles where no read was issued in the previous cycle.
REQ-032 START in any state other than IDLE SHALL be ignored.
REQ-033 ABORT=1 in CLEAR, FEED or FLUSH SHALL force IDLE on the next cycle, zero all skew registers, and produce no DONE.
REQ-034 ABORT in IDLE or DONE SHALL be ignored, so DONE still pulses.
REQ-035 If START and ABORT are both 1 in IDLE, START SHALL win.
REQ-036 K_LEN=65535 SHALL be supported with no internal counter overflow; the feed counter is 16 bits and the flush counter is sized for HPE+VPE+PIPE_LAT.

Reset
REQ-037 RST=1 at a rising edge SHALL force IDLE, regardless of the current state.
REQ-038 On reset, MEM_RE, SA_CLR, SA_EN, BUSY and DONE SHALL be 0, and MEM_ADDR, AA, BB and all skew/valid registers SHALL be 0.
REQ-039 Reset mid-job SHALL behave as ABORT with no DONE.
REQ-040 START asserted together with RST SHALL be ignored.

Verification
REQ-041 The bench SHALL cover the following scenarios (HPE=VPE=4, WIDTH=8, PIPE_LAT=2, START sampled in cycle 0):
- Nominal: K_LEN=3, BASE_ADDR=0x10 -> SA_CLR in cycle 1; MEM_ADDR 0x10/0x11/0x12 in cycles 2-4; FLUSH in cycles 5-14; DONE=1 in cycle 15; BUSY=1 in cycles 1-15.
- Skew: buffer word with A={1,2,3,4} (lane 0..3) at 0x10 -> AA lane 0=1 in cycle 4, lane 1=2 in cycle 5, lane 2=3 in cycle 6, lane 3=4 in cycle 7; each lane is 0 in every other cycle.
- Zero length: K_LEN=0 -> SA_CLR in cycle 1, DONE in cycle 2, MEM_RE never 1.
- Abort: K_LEN=8 with ABORT in cycle 5 -> IDLE in cycle 6, AA=BB=0 from cycle 6, no DONE; a new START in cycle 6 is accepted.
- Wrap and busy-ignore: AW=14, BASE_ADDR=0x3FFE, K_LEN=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; a START pulse in cycle 3 has no effect.
- Reset mid-FEED: RST=1 in cycle 3 -> all outputs 0 in cycle 4, no DONE.
